// File: rtl/mul_div_seq.sv
// mul_div_seq: iterative signed Booth multiply / restoring divide, one bit per clock.
// Define UNSIGNED_OP_EN to add the is_unsigned operand-mode input.
module mul_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             op_div,
`ifdef UNSIGNED_OP_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] z_hi,
    output logic [WIDTH-1:0] z_lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t state, state_nx;
    logic accept, uns, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [CW-1:0] cnt;
    logic [WIDTH+1:0] hi, mext, sum;
    logic [WIDTH-1:0] lo, rsub;
    logic [WIDTH:0] m, rq;
    logic qm1, div_r, neg_q, neg_r, dz, corr, ge;
`ifdef UNSIGNED_OP_EN
    assign uns = is_unsigned;
`else
    assign uns = 1'b0;
`endif
    always_comb begin
        accept   = start && (state == IDLE || state == DONE);
        state_nx = accept ? RUN :
                   state == RUN ? (cnt == LAST ? FIX : RUN) :
                   state == FIX ? DONE : IDLE;
    end
    assign busy = state == RUN || state == FIX;
    assign done = state == DONE;
    always_comb begin
        a_neg = a[WIDTH-1] & ~uns;
        b_neg = b[WIDTH-1] & ~uns;
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        mext  = {m[WIDTH], m};
        sum   = {lo[0], qm1} == 2'b01 ? hi + mext :
                {lo[0], qm1} == 2'b10 ? hi - mext : hi;
        rq    = {hi[WIDTH-1:0], lo[WIDTH-1]};
        ge    = rq >= {1'b0, m[WIDTH-1:0]};
        rsub  = rq[WIDTH-1:0] - m[WIDTH-1:0];
    end
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= IDLE;
        else        state <= state_nx;
    end
    // hi is widened by two bits so Booth add/subtract of a most-negative multiplicand cannot overflow
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            m           <= '0;
            qm1         <= 1'b0;
            div_r       <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            corr        <= 1'b0;
            z_hi        <= '0;
            z_lo        <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            hi    <= '0;
            qm1   <= 1'b0;
            div_r <= op_div;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            dz    <= b == '0;
            corr  <= uns & b[WIDTH-1] & ~op_div;
            lo    <= op_div ? a_mag : b;
            m     <= op_div ? {1'b0, b_mag} : {a[WIDTH-1] & ~uns, a};
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            if (div_r) begin
                hi <= {2'b00, ge ? rsub : rq[WIDTH-1:0]};
                lo <= {lo[WIDTH-2:0], ge};
            end else begin
                hi  <= {sum[WIDTH+1], sum[WIDTH+1:1]};
                lo  <= {sum[0], lo[WIDTH-1:1]};
                qm1 <= lo[0];
            end
        end else if (state == FIX) begin
            // unsigned multiplier with MSB set was iterated as negative; add a<<WIDTH back
            z_hi        <= div_r ? (neg_r ? -hi[WIDTH-1:0] : hi[WIDTH-1:0]) :
                           hi[WIDTH-1:0] + (corr ? m[WIDTH-1:0] : '0);
            z_lo        <= div_r ? (dz ? '1 : neg_q ? -lo : lo) : lo;
            div_by_zero <= div_r & dz;
        end
    end
endmodule
